pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the single-cycle core; successor to the plain pc register.
//  Holds the PC and selects the next PC: sequential, branch, jump, call or return.
//  Provides stall (enable) and a circular return-address stack (RAS) for call/ret.
//  Feeds instruction memory address and the pc+INC value used by the link/writeback path.
// PARAMETERS
//  WIDTH      32   PC / target width in bits
//  RESET_VEC  0    PC value loaded on reset (WIDTH bits)
//  INC        4    sequential increment (bytes per instruction)
//  RAS_DEPTH  4    return-address stack entries, power of two, >=2
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous reset, active-high
//  en            in   1      1 = advance PC this cycle, 0 = stall (hold everything)
//  branch_taken  in   1      take branch_target
//  branch_target in   WIDTH  branch destination
//  jump          in   1      take jump_target (no link)
//  call          in   1      take jump_target, push pc_plus on RAS
//  jump_target   in   WIDTH  jump/call destination
//  ret           in   1      pop RAS, take popped address
//  pc_out        out  WIDTH  current PC (registered)
//  pc_plus       out  WIDTH  pc_out + INC (combinational, mod 2^WIDTH)
//  ras_empty     out  1      RAS holds 0 entries
//  ras_full      out  1      RAS holds RAS_DEPTH entries
//  ras_err       out  1      sticky: ret on empty, or call+ret together
// BEHAVIOUR
//  - Reset (rst=1 at clk edge, overrides all): pc_out=RESET_VEC, RAS count=0, top ptr=0,
//    ras_empty=1, ras_full=0, ras_err=0. Reset mid-sequence discards all RAS contents.
//  - en=0: pc_out, RAS contents/pointer/count and ras_err hold; all control inputs ignored.
//  - en=1, next-PC priority (one applied per cycle, updated at next rising edge, latency 1):
//    1 ret  2 call  3 jump  4 branch_taken  5 sequential (pc_out+INC).
//  - ret with count>0: pc_out<=RAS[top]; top ptr decrements (mod RAS_DEPTH); count-1.
//  - ret with count==0: pc_out<=pc_plus, RAS unchanged, ras_err<=1.
//  - call+ret same cycle: ret executes as above, push suppressed, ras_err<=1.
//  - call: pc_out<=jump_target; push pc_plus: top ptr increments (mod RAS_DEPTH), write entry.
//    count<RAS_DEPTH -> count+1; count==RAS_DEPTH -> oldest entry overwritten (wrap),
//    count stays RAS_DEPTH, no error (deep recursion loses oldest return only).
//  - jump / branch: no RAS effect; lower-priority requests same cycle are dropped.
//  - Arithmetic: all adds unsigned, truncated to WIDTH bits; PC wraps 2^WIDTH-INC -> 0.
//  - Targets used verbatim (no alignment masking). ras_err cleared only by rst.
//  - ras_empty/ras_full derived from registered count, valid the cycle after update.
// STRUCTURE
//  - pc_defs.vh: next-PC select encoding localparams (SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL,
//    SEL_RET) and clog2-style pointer-width macro; shared with the control decoder.
//  - Sub-module pc_ras: circular stack (push, pop, data_in, top_out, count, empty, full),
//    params DEPTH/WIDTH, same clk/rst. pc_unit holds PC reg, priority mux, ras_err flag.
// TESTING
//  1 rst=1 two cycles, RESET_VEC=32'h0000_0100 -> pc_out=0x100, ras_empty=1, ras_err=0;
//    release, en=1 idle 3 cycles -> 0x104, 0x108, 0x10C.
//  2 en=0 for 2 cycles with branch_taken=1 target 0x800 -> pc_out holds; en=1 -> 0x800.
//  3 pc=0x200, call target 0x1000 -> pc=0x1000, ras top=0x204; ret -> pc=0x204, ras_empty=1.
//  4 RAS_DEPTH=4, 5 nested calls pushing 0x14,0x24,0x34,0x44,0x54 -> ras_full=1;
//    5 rets -> 0x54,0x44,0x34,0x24 then 5th ret: pc=pc+4, ras_err=1.
//  5 same cycle ret+call+jump+branch with RAS top 0x300 -> pc=0x300, no push, ras_err=1;
//    jump+branch only -> jump_target wins.
//  6 WIDTH=32, pc=0xFFFF_FFFC sequential -> 0x0000_0000; rst during pending call chain
//    -> RAS empty, pc=RESET_VEC next cycle.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
// Next-PC select encoding and RAS pointer sizing.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_CALL = 3'd3,
        SEL_RET  = 3'd4
    } sel_e;

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// A push when full overwrites the oldest entry.
module pc_ras
    import pc_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        data_in,
    output logic [WIDTH-1:0]        top_out,
    output logic [ptr_w(DEPTH):0]   count,
    output logic                    empty,
    output logic                    full
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_inc;
    logic [PW-1:0]    top_dec;
    logic             do_pop;
    logic             do_push;

    assign top_inc = top + PW'(1);
    assign top_dec = top - PW'(1);
    assign do_pop  = pop && (count != '0);
    assign do_push = push && !pop;
    assign top_out = mem[top];
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));

    // Pointer and occupancy; pop wins over push.
    always_ff @(posedge clk) begin
        if (rst) begin
            top   <= '0;
            count <= '0;
        end else if (do_pop) begin
            top   <= top_dec;
            count <= count - 1'b1;
        end else if (do_push) begin
            top <= top_inc;
            if (!full) begin
                count <= count + 1'b1;
            end
        end
    end

    // Entry storage; stale data is masked by count after reset.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[top_inc] <= data_in;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with prioritised next-PC select,
// stall, and a return-address stack for call/ret.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int PW = ptr_w(RAS_DEPTH);

    sel_e             sel;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic [PW:0]      ras_cnt;
    logic             ras_has;

    assign pc_plus = pc_out + WIDTH'(INC);
    assign ras_has = (ras_cnt != '0);

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (WIDTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push    (en && call),
        .pop     (en && ret),
        .data_in (pc_plus),
        .top_out (ras_top),
        .count   (ras_cnt),
        .empty   (ras_empty),
        .full    (ras_full)
    );

    // Fixed-priority select: ret > call > jump > branch > seq.
    always_comb begin
        sel = SEL_SEQ;
        if (ret)               sel = SEL_RET;
        else if (call)         sel = SEL_CALL;
        else if (jump)         sel = SEL_JMP;
        else if (branch_taken) sel = SEL_BR;
    end

    // Next-PC mux; an empty-stack ret falls through to pc_plus.
    always_comb begin
        pc_next = pc_plus;
        case (sel)
            SEL_RET:  pc_next = ras_has ? ras_top : pc_plus;
            SEL_CALL: pc_next = jump_target;
            SEL_JMP:  pc_next = jump_target;
            SEL_BR:   pc_next = branch_target;
            default:  pc_next = pc_plus;
        endcase
    end

    // PC register and sticky stack-misuse flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out  <= RESET_VEC;
            ras_err <= 1'b0;
        end else if (en) begin
            pc_out <= pc_next;
            if (ret && (!ras_has || call)) begin
                ras_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit.
// Each task drives one scenario and checks inline.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic        call;
    logic [31:0] jump_target;
    logic        ret;
    logic [31:0] pc_out;
    logic [31:0] pc_plus;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int n_cmp = 0;
    int n_bad = 0;

    pc_unit #(
        .WIDTH     (32),
        .RESET_VEC (32'h0000_0100),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .pc_out        (pc_out),
        .pc_plus       (pc_plus),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_err       (ras_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        en            = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        call          = 1'b0;
        jump_target   = 32'h0;
        ret           = 1'b0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h104;
        exp_seq[1] = 32'h108;
        exp_seq[2] = 32'h10C;
        clr();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (pc_out !== 32'h100) begin
            n_bad++;
            $display("FAIL reset_pc got=%h want=%h", pc_out, 32'h100);
        end
        n_cmp++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got e=%b f=%b err=%b want e=1 f=0 err=0",
                     ras_empty, ras_full, ras_err);
        end
        n_cmp++;
        if (pc_plus !== 32'h104) begin
            n_bad++;
            $display("FAIL reset_pc_plus got=%h want=%h", pc_plus, 32'h104);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (pc_out !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL seq_%0d got=%h want=%h", i, pc_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_stall();
        en            = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h800;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (pc_out !== 32'h10C) begin
                n_bad++;
                $display("FAIL stall_%0d got=%h want=%h", i, pc_out, 32'h10C);
            end
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (pc_out !== 32'h800) begin
            n_bad++;
            $display("FAIL stall_release got=%h want=%h", pc_out, 32'h800);
        end
        clr();
    endtask

    task automatic test_call_ret();
        do_reset();
        jump        = 1'b1;
        jump_target = 32'h200;
        tick();
        n_cmp++;
        if (pc_out !== 32'h200) begin
            n_bad++;
            $display("FAIL jump_200 got=%h want=%h", pc_out, 32'h200);
        end
        jump        = 1'b0;
        call        = 1'b1;
        jump_target = 32'h1000;
        tick();
        n_cmp++;
        if (pc_out !== 32'h1000 || ras_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL call got pc=%h e=%b want pc=%h e=0",
                     pc_out, ras_empty, 32'h1000);
        end
        call = 1'b0;
        ret  = 1'b1;
        tick();
        n_cmp++;
        if (pc_out !== 32'h204 || ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ret got pc=%h e=%b err=%b want pc=%h e=1 err=0",
                     pc_out, ras_empty, ras_err, 32'h204);
        end
        clr();
    endtask

    task automatic test_ras_wrap();
        logic [31:0] tgt;
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'h54;
        exp_ret[1] = 32'h44;
        exp_ret[2] = 32'h34;
        exp_ret[3] = 32'h24;
        do_reset();
        jump        = 1'b1;
        jump_target = 32'h10;
        tick();
        jump = 1'b0;
        call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tgt         = 32'h20 + 32'h10 * i;
            jump_target = tgt;
            tick();
            n_cmp++;
            if (pc_out !== tgt) begin
                n_bad++;
                $display("FAIL nest_call_%0d got=%h want=%h", i, pc_out, tgt);
            end
        end
        n_cmp++;
        if (ras_full !== 1'b1 || ras_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL ras_full got f=%b e=%b want f=1 e=0", ras_full, ras_empty);
        end
        call = 1'b0;
        ret  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (pc_out !== exp_ret[i]) begin
                n_bad++;
                $display("FAIL nest_ret_%0d got=%h want=%h", i, pc_out, exp_ret[i]);
            end
        end
        n_cmp++;
        if (ras_empty !== 1'b1 || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL drained got e=%b err=%b want e=1 err=0", ras_empty, ras_err);
        end
        tick();
        n_cmp++;
        if (pc_out !== 32'h28 || ras_err !== 1'b1) begin
            n_bad++;
            $display("FAIL ret_empty got pc=%h err=%b want pc=%h err=1",
                     pc_out, ras_err, 32'h28);
        end
        clr();
    endtask

    task automatic test_priority();
        do_reset();
        jump        = 1'b1;
        jump_target = 32'h2FC;
        tick();
        jump        = 1'b0;
        call        = 1'b1;
        jump_target = 32'h500;
        tick();
        n_cmp++;
        if (pc_out !== 32'h500) begin
            n_bad++;
            $display("FAIL prio_setup got=%h want=%h", pc_out, 32'h500);
        end
        ret           = 1'b1;
        call          = 1'b1;
        jump          = 1'b1;
        jump_target   = 32'h600;
        branch_taken  = 1'b1;
        branch_target = 32'h900;
        tick();
        n_cmp++;
        if (pc_out !== 32'h300 || ras_empty !== 1'b1 || ras_err !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_ret got pc=%h e=%b err=%b want pc=%h e=1 err=1",
                     pc_out, ras_empty, ras_err, 32'h300);
        end
        ret  = 1'b0;
        call = 1'b0;
        tick();
        n_cmp++;
        if (pc_out !== 32'h600 || ras_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL prio_jump got pc=%h e=%b want pc=%h e=1",
                     pc_out, ras_empty, 32'h600);
        end
        clr();
    endtask

    task automatic test_wrap_reset();
        do_reset();
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick();
        jump = 1'b0;
        tick();
        n_cmp++;
        if (pc_out !== 32'h0) begin
            n_bad++;
            $display("FAIL pc_wrap got=%h want=%h", pc_out, 32'h0);
        end
        call        = 1'b1;
        jump_target = 32'h40;
        tick();
        jump_target = 32'h80;
        tick();
        n_cmp++;
        if (ras_empty !== 1'b0 || pc_out !== 32'h80) begin
            n_bad++;
            $display("FAIL chain got pc=%h e=%b want pc=%h e=0", pc_out, ras_empty, 32'h80);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (pc_out !== 32'h100 || ras_empty !== 1'b1 || ras_full !== 1'b0
            || ras_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset got pc=%h e=%b f=%b err=%b want pc=%h e=1 f=0 err=0",
                     pc_out, ras_empty, ras_full, ras_err, 32'h100);
        end
        rst = 1'b0;
        clr();
        ret = 1'b1;
        tick();
        n_cmp++;
        if (pc_out !== 32'h104 || ras_err !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_ret got pc=%h err=%b want pc=%h err=1",
                     pc_out, ras_err, 32'h104);
        end
        clr();
    endtask

    initial begin
        rst = 1'b1;
        clr();
        test_reset();
        test_stall();
        test_call_ret();
        test_ras_wrap();
        test_priority();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
